instr_fetch_unit: RTL and testbench

// - Producer side of the Control_Unit instruction interface. Holds the PC and reads words from a synchronous instruction memory.
// - Presents one 32-bit instruction per cycle, with a valid flag, to the decode/control stage.
// - Accepts stall and taken-branch feedback from downstream. Halts on a sentinel word.
// - Sits between instruction memory and Control_Unit.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_skid_buf.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word layout, halt sentinel and fetch FSM states.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory port plus the instruction hand-off to the control unit.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output imem_addr, imem_rd_en, instruction, instr_valid, instr_pc,
    input  imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, imem_rd_en, instruction, instr_valid, instr_pc,
    output imem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register catching a fetch that returns while downstream is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i || pop_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, IDLE/RUN/HALT control, squash of in-flight reads on redirect,
// and a skid entry so a stall never drops a returning word.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 8,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               halted,
  instr_fetch_unit_if.master bus
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic               inflight_q, inflight_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

  logic               rd_en;
  logic               ret_live;
  logic               ret_halt;
  logic               skid_load, skid_pop, skid_flush, skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [ADDR_W-1:0]  skid_pc;

  fetch_skid_buf #(
    .ADDR_W(ADDR_W)
  ) u_skid (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .data_i  (bus.imem_rdata),
    .pc_i    (tag_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  // A returning read is squashed by a redirect in the same cycle.
  assign ret_live = (state_q == RUN) && inflight_q && !bus.branch_taken;
  assign ret_halt = ret_live && (bus.imem_rdata == HALT_WORD);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    rd_en      = 1'b0;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (bus.branch_taken) begin
          pc_d       = bus.branch_target;
          skid_flush = 1'b1;
          valid_d    = 1'b0;
        end else if (ret_halt) begin
          // A word already presented stays up until downstream takes it.
          state_d    = HALT;
          skid_flush = 1'b1;
          if (!bus.stall) valid_d = 1'b0;
        end else if (bus.stall) begin
          if (ret_live) skid_load = 1'b1;
        end else begin
          rd_en      = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          inflight_d = 1'b1;
          tag_d      = pc_q;
          if (skid_valid) begin
            skid_pop   = 1'b1;
            instr_d    = skid_data;
            instr_pc_d = skid_pc;
            valid_d    = 1'b1;
          end else if (ret_live) begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = tag_q;
            valid_d    = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      HALT: begin
        if (!bus.stall) valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.imem_rd_en  = rd_en;
  assign bus.imem_addr   = rd_en ? pc_q : '0;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one 8-bit-address unit with a halting program and a
// 2-bit-address unit for PC wrap, each fed by a one-cycle synchronous memory model.
module tb_instr_fetch_unit;

  localparam logic [31:0] W0   = 32'h0061_1023;
  localparam logic [31:0] W1   = 32'h0081_182B;
  localparam logic [31:0] W2   = 32'h0081_1804;
  localparam logic [31:0] WHLT = 32'hFFFF_FFFF;

  logic clk;
  logic reset;
  logic start;
  logic start2;
  logic halted;
  logic halted2;

  int n_checks;
  int n_fails;

  logic [31:0] mem  [256];
  logic [31:0] mem2 [4];

  instr_fetch_unit_if #(.ADDR_W(8)) bus8 ();
  instr_fetch_unit_if #(.ADDR_W(2)) bus2 ();

  instr_fetch_unit #(.ADDR_W(8)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .halted (halted),
    .bus    (bus8)
  );

  instr_fetch_unit #(.ADDR_W(2)) u_wrap (
    .clk    (clk),
    .reset  (reset),
    .start  (start2),
    .halted (halted2),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus8.imem_rd_en) bus8.imem_rdata <= mem[bus8.imem_addr];
    if (bus2.imem_rd_en) bus2.imem_rdata <= mem2[bus2.imem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] w,
                           input logic [7:0] pc);
    check_eq({tag, ".valid"}, 32'(bus8.instr_valid), 32'(v));
    check_eq({tag, ".instr"}, bus8.instruction, w);
    check_eq({tag, ".pc"}, 32'(bus8.instr_pc), 32'(pc));
  endtask

  task automatic check_reset_state(input string tag);
    check_out(tag, 1'b0, 32'h0, 8'd0);
    check_eq({tag, ".rd_en"}, 32'(bus8.imem_rd_en), 32'd0);
    check_eq({tag, ".addr"}, 32'(bus8.imem_addr), 32'd0);
    check_eq({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    bus8.stall = 1'b0;
    bus8.branch_taken = 1'b0;
    bus8.branch_target = '0;
    tick(2);
    reset = 1'b0;
  endtask

  // Leaves the bench just after edge 0, the edge that samples start.
  task automatic start_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] wrap_w [5];
    logic [1:0]  wrap_pc [5];
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = WHLT;
    mem2[0] = W0; mem2[1] = W1; mem2[2] = W1; mem2[3] = W2;
    bus2.stall = 1'b0;
    bus2.branch_taken = 1'b0;
    bus2.branch_target = '0;

    // Straight-line run to the sentinel; start re-pulsed in RUN and in HALT.
    do_reset();
    check_reset_state("reset");
    start_run();
    check_eq("c0.rd_en", 32'(bus8.imem_rd_en), 32'd1);
    check_eq("c0.addr", 32'(bus8.imem_addr), 32'd0);
    tick(1);
    check_eq("c1.valid", 32'(bus8.instr_valid), 32'd0);
    tick(1);
    check_out("run.c2", 1'b1, W0, 8'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_out("run.c3", 1'b1, W1, 8'd1);
    tick(1);
    check_out("run.c4", 1'b1, W2, 8'd2);
    tick(1);
    check_eq("run.c5.valid", 32'(bus8.instr_valid), 32'd0);
    check_eq("run.c5.halted", 32'(halted), 32'd1);
    check_eq("run.c5.rd_en", 32'(bus8.imem_rd_en), 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check_eq("halt.hold", 32'(halted), 32'd1);
    check_eq("halt.valid", 32'(bus8.instr_valid), 32'd0);

    // Stall over cycles 3-5: hold, skid capture, no-gap release.
    do_reset();
    start_run();
    tick(3);
    bus8.stall = 1'b1;
    tick(1);
    check_out("stall.c4", 1'b1, W1, 8'd1);
    check_eq("stall.c4.rd_en", 32'(bus8.imem_rd_en), 32'd0);
    tick(1);
    check_out("stall.c5", 1'b1, W1, 8'd1);
    tick(1);
    check_out("stall.c6", 1'b1, W1, 8'd1);
    bus8.stall = 1'b0;
    tick(1);
    check_out("stall.c7", 1'b1, W2, 8'd2);
    tick(1);
    check_eq("stall.c8.valid", 32'(bus8.instr_valid), 32'd0);
    check_eq("stall.c8.halted", 32'(halted), 32'd1);

    // Branch to 0 while pc2 is shown; the returning sentinel is squashed.
    do_reset();
    start_run();
    tick(4);
    bus8.branch_taken = 1'b1;
    bus8.branch_target = 8'd0;
    tick(1);
    bus8.branch_taken = 1'b0;
    check_eq("br.c5.valid", 32'(bus8.instr_valid), 32'd0);
    check_eq("br.c5.halted", 32'(halted), 32'd0);
    tick(1);
    check_eq("br.c6.valid", 32'(bus8.instr_valid), 32'd0);
    tick(1);
    check_out("br.c7", 1'b1, W0, 8'd0);
    tick(1);
    check_out("br.c8", 1'b1, W1, 8'd1);
    tick(1);
    check_out("br.c9", 1'b1, W2, 8'd2);
    tick(1);
    check_eq("br.c10.halted", 32'(halted), 32'd1);

    // Branch with stall while the skid holds pc2: skid word must be dropped.
    do_reset();
    start_run();
    tick(3);
    bus8.stall = 1'b1;
    tick(1);
    bus8.branch_taken = 1'b1;
    bus8.branch_target = 8'd1;
    tick(1);
    bus8.branch_taken = 1'b0;
    bus8.stall = 1'b0;
    check_eq("brst.c5.valid", 32'(bus8.instr_valid), 32'd0);
    tick(1);
    check_eq("brst.c6.valid", 32'(bus8.instr_valid), 32'd0);
    tick(1);
    check_out("brst.c7", 1'b1, W1, 8'd1);
    tick(1);
    check_out("brst.c8", 1'b1, W2, 8'd2);

    // Sentinel returns under stall: presented word holds until stall drops.
    do_reset();
    start_run();
    tick(4);
    bus8.stall = 1'b1;
    tick(1);
    check_eq("hst.c5.halted", 32'(halted), 32'd1);
    check_out("hst.c5", 1'b1, W2, 8'd2);
    bus8.stall = 1'b0;
    tick(1);
    check_eq("hst.c6.valid", 32'(bus8.instr_valid), 32'd0);
    check_eq("hst.c6.halted", 32'(halted), 32'd1);

    // 2-bit PC wraps 3 -> 0.
    do_reset();
    wrap_w  = '{W0, W1, W1, W2, W0};
    wrap_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq($sformatf("wrap.c%0d.valid", i + 2), 32'(bus2.instr_valid), 32'd1);
      check_eq($sformatf("wrap.c%0d.instr", i + 2), bus2.instruction, wrap_w[i]);
      check_eq($sformatf("wrap.c%0d.pc", i + 2), 32'(bus2.instr_pc), 32'(wrap_pc[i]));
    end

    // Reset while stalled with the skid full, then a clean restart.
    do_reset();
    start_run();
    tick(3);
    bus8.stall = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus8.stall = 1'b0;
    check_reset_state("midrst");
    start_run();
    check_eq("restart.c0.rd_en", 32'(bus8.imem_rd_en), 32'd1);
    check_eq("restart.c0.addr", 32'(bus8.imem_addr), 32'd0);
    tick(1);
    check_eq("restart.c1.valid", 32'(bus8.instr_valid), 32'd0);
    tick(1);
    check_out("restart.c2", 1'b1, W0, 8'd0);
    tick(1);
    check_out("restart.c3", 1'b1, W1, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
